// File: rtl/median_arbiter.sv
// Round-robin arbiter sharing one 9-sample median core among NREQ requesters.
// Optional WAIT timeout abort is compiled in with `define MEDIAN_ARB_TIMEOUT_EN.
module median_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int NSAMPLES = 9,
    parameter int TIMEOUT  = 50
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ,
    output logic [NREQ-1:0]    GNT,
    input  logic [NREQ-1:0]    REQ_DSI,
    input  logic [NREQ*DW-1:0] REQ_DI,
    output logic [DW-1:0]      RES_DO,
    output logic [NREQ-1:0]    RES_VALID,
    output logic               ERR,
    output logic               BUSY,
    output logic               M_DSI,
    output logic [DW-1:0]      M_DI,
    output logic               M_nRST,
    input  logic               M_DSO,
    input  logic [DW-1:0]      M_DO
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(NSAMPLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LOAD,
        S_WAIT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]     g_idx_q, g_idx_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     res_do_q, res_do_d;
    logic [NREQ-1:0]   res_valid_q, res_valid_d;
    logic              err_q, err_d;
    logic              m_dsi_q, m_dsi_d;
    logic [DW-1:0]     m_di_q, m_di_d;
    logic              m_nrst_q, m_nrst_d;
`ifdef MEDIAN_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]     tmo_q, tmo_d;
`endif

    logic [DW-1:0]     req_di_arr [NREQ];
    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     cand_idx;
    logic [PW-1:0]     ptr_next;
    logic              sel_dsi;
    logic              sel_req;
    logic [DW-1:0]     sel_di;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_di_arr[i] = REQ_DI[i*DW +: DW];
    end

    assign sel_dsi  = REQ_DSI[g_idx_q];
    assign sel_req  = REQ[g_idx_q];
    assign sel_di   = req_di_arr[g_idx_q];
    assign ptr_next = (g_idx_q == PW'(NREQ - 1)) ? '0 : g_idx_q + PW'(1);

    // First requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!pick_found && REQ[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // NOTE: every signal gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        g_idx_d     = g_idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        res_do_d    = res_do_q;
        res_valid_d = '0;
        err_d       = 1'b0;
        m_dsi_d     = 1'b0;
        m_di_d      = '0;
        m_nrst_d    = 1'b1;
`ifdef MEDIAN_ARB_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    g_idx_d         = pick_idx;
                    state_d         = S_GRANT;
                end
            end
            S_GRANT: begin
                if (sel_dsi) begin
                    m_dsi_d = 1'b1;
                    m_di_d  = sel_di;
                    cnt_d   = CW'(1);
                    state_d = S_LOAD;
                end else if (!sel_req) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (sel_dsi) begin
                    m_dsi_d = 1'b1;
                    m_di_d  = sel_di;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(NSAMPLES - 1)) begin
                        state_d = S_WAIT;
`ifdef MEDIAN_ARB_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end else begin
                    // Broken burst: reset the core while ERR is visible.
                    err_d    = 1'b1;
                    m_nrst_d = 1'b0;
                    gnt_d    = '0;
                    state_d  = S_ABORT;
                end
            end
            S_WAIT: begin
                if (M_DSO) begin
                    res_do_d    = M_DO;
                    res_valid_d = gnt_q;
                    gnt_d       = '0;
                    state_d     = S_DONE;
`ifdef MEDIAN_ARB_TIMEOUT_EN
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    m_nrst_d = 1'b0;
                    gnt_d    = '0;
                    state_d  = S_ABORT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
`endif
                end
            end
            S_DONE: begin
                ptr_d   = ptr_next;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                ptr_d   = ptr_next;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop here is reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            g_idx_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            res_do_q    <= '0;
            res_valid_q <= '0;
            err_q       <= 1'b0;
            m_dsi_q     <= 1'b0;
            m_di_q      <= '0;
            m_nrst_q    <= 1'b0;
`ifdef MEDIAN_ARB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            g_idx_q     <= g_idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            res_do_q    <= res_do_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            m_dsi_q     <= m_dsi_d;
            m_di_q      <= m_di_d;
            m_nrst_q    <= m_nrst_d;
`ifdef MEDIAN_ARB_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign GNT       = gnt_q;
    assign RES_DO    = res_do_q;
    assign RES_VALID = res_valid_q;
    assign ERR       = err_q;
    assign BUSY      = (state_q != S_IDLE);
    assign M_DSI     = m_dsi_q;
    assign M_DI      = m_di_q;
    assign M_nRST    = m_nrst_q;

endmodule
